// File: rtl/jk_pkg.sv
// Shared types and constants for the JK universal register: operation modes
// and the direction encodings used by count and shift.
package jk_pkg;

  typedef enum logic [2:0] {
    MODE_JK    = 3'd0,
    MODE_LOAD  = 3'd1,
    MODE_COUNT = 3'd2,
    MODE_SHIFT = 3'd3,
    MODE_CLEAR = 3'd4,
    MODE_SET   = 3'd5,
    MODE_RSV6  = 3'd6,
    MODE_RSV7  = 3'd7
  } jk_mode_e;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with clock enable and a synchronous, active-low
// reset to a per-cell value.
module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic j,
  input  logic k,
  input  logic rst_val,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= rst_val;
    end else if (en) begin
      unique case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_universal_reg.sv
// WIDTH-bit universal register built from JK cells: raw JK, load, up/down
// count, bidirectional shift, clear and set, plus terminal count and overflow.
module jk_universal_reg
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  jk_mode_e         mode,
  input  logic             dir,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] je, ke;
  logic [WIDTH-1:0] up_chain, dn_chain, t;
  logic [WIDTH-1:0] shift_src;

  // Ripple prefix ANDs: bit i toggles once all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_chain[0] = 1'b1;
    dn_chain[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_chain[i] = up_chain[i-1] & q[i-1];
      dn_chain[i] = dn_chain[i-1] & ~q[i-1];
    end
    t = (dir == DIR_DOWN) ? dn_chain : up_chain;
  end

  assign shift_src = (dir == DIR_RIGHT) ? {ser_in, q[WIDTH-1:1]}
                                        : {q[WIDTH-2:0], ser_in};

  // NOTE: je/ke get defaults before the case so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    je = '0;
    ke = '0;
    unique case (mode)
      MODE_JK:    begin je = j;         ke = k;          end
      MODE_LOAD:  begin je = d;         ke = ~d;         end
      MODE_COUNT: begin je = t;         ke = t;          end
      MODE_SHIFT: begin je = shift_src; ke = ~shift_src; end
      MODE_CLEAR: begin je = '0;        ke = '1;         end
      MODE_SET:   begin je = '1;        ke = '0;         end
      default:    begin je = '0;        ke = '0;         end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .j       (je[i]),
      .k       (ke[i]),
      .rst_val (RESET_VAL[i]),
      .q       (q[i])
    );
  end

  assign tc = en && (mode == MODE_COUNT) &&
              (((dir == DIR_UP) && (q == '1)) || ((dir == DIR_DOWN) && (q == '0)));

  // Clear wins over set; the wrap edge is exactly the edge where tc is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (en) begin
      if (mode == MODE_CLEAR) begin
        ovf <= 1'b0;
      end else if (tc) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule
